// File: rtl/l2_arbiter_rr.sv
// ============================================================================
// Module   : l2_arbiter_rr
// Purpose  : Round-robin arbiter sharing one L2 port between I- and D-caches.
// Revision : 1.0
// ============================================================================
`default_nettype none

module l2_arbiter_rr #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              I_read,
    input  logic [ADDR_W-1:0] I_addr,
    output logic [LINE_W-1:0] I_rdata,
    output logic              I_resp,

    input  logic              D_read,
    input  logic              D_write,
    input  logic [ADDR_W-1:0] D_addr,
    input  logic [LINE_W-1:0] D_wdata,
    output logic [LINE_W-1:0] D_rdata,
    output logic              D_resp,

    output logic              L2_read,
    output logic              L2_write,
    output logic [ADDR_W-1:0] L2_addr,
    output logic [LINE_W-1:0] L2_wdata,
    input  logic [LINE_W-1:0] L2_rdata,
    input  logic              L2_resp
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;
    localparam logic [1:0] RECOVER = 2'd3;

    logic [1:0] r_state;
    logic       r_last_d;
    logic       w_d_req;
    logic       w_pick_i;

    assign w_d_req  = D_read | D_write;
    // I wins when alone, or on a tie when D was served last.
    assign w_pick_i = I_read & (~w_d_req | r_last_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_last_d <= 1'b1;
            L2_read  <= 1'b0;
            L2_write <= 1'b0;
            L2_addr  <= '0;
            L2_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_i) begin
                        r_state  <= GRANT_I;
                        L2_addr  <= I_addr;
                        L2_read  <= 1'b1;
                        L2_write <= 1'b0;
                        r_last_d <= 1'b0;
                    end else if (w_d_req) begin
                        r_state  <= GRANT_D;
                        L2_addr  <= D_addr;
                        L2_wdata <= D_wdata;
                        L2_write <= D_write;
                        L2_read  <= ~D_write;
                        r_last_d <= 1'b1;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (L2_resp) begin
                        r_state  <= RECOVER;
                        L2_read  <= 1'b0;
                        L2_write <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign I_resp  = (r_state == GRANT_I) & L2_resp;
    assign D_resp  = (r_state == GRANT_D) & L2_resp;
    assign I_rdata = L2_rdata;
    assign D_rdata = L2_rdata;

endmodule

`default_nettype wire

// File: tb/tb_l2_arbiter_rr.sv
// ============================================================================
// Module   : tb_l2_arbiter_rr
// Purpose  : Scoreboard bench for l2_arbiter_rr with randomized cache traffic.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_l2_arbiter_rr;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic              clk;
    logic              rst_n;
    logic              I_read;
    logic [ADDR_W-1:0] I_addr;
    logic [LINE_W-1:0] I_rdata;
    logic              I_resp;
    logic              D_read;
    logic              D_write;
    logic [ADDR_W-1:0] D_addr;
    logic [LINE_W-1:0] D_wdata;
    logic [LINE_W-1:0] D_rdata;
    logic              D_resp;
    logic              L2_read;
    logic              L2_write;
    logic [ADDR_W-1:0] L2_addr;
    logic [LINE_W-1:0] L2_wdata;
    logic [LINE_W-1:0] L2_rdata;
    logic              L2_resp;

    l2_arbiter_rr #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .I_read(I_read), .I_addr(I_addr), .I_rdata(I_rdata), .I_resp(I_resp),
        .D_read(D_read), .D_write(D_write), .D_addr(D_addr), .D_wdata(D_wdata),
        .D_rdata(D_rdata), .D_resp(D_resp),
        .L2_read(L2_read), .L2_write(L2_write), .L2_addr(L2_addr), .L2_wdata(L2_wdata),
        .L2_rdata(L2_rdata), .L2_resp(L2_resp)
    );

    typedef struct {
        bit                who_d;
        bit                rd;
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        int                cyc;
    } cmd_t;

    typedef struct {
        bit                who_d;
        logic [LINE_W-1:0] data;
    } resp_t;

    cmd_t  cmd_q[$];
    resp_t resp_q[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit served_d_last;   // reference: which cache the L2 served most recently
    bit post_resp;       // driver is at the first negedge after a response

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got event, expected none (t=%0t)", name, $time);
    endtask

    function automatic logic [LINE_W-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ------------------------------------------------------------------ monitor
    initial begin
        bit    prev_cmd;
        bit    active;
        bit    after_resp;
        bit    cmd;
        cmd_t  cur;
        cmd_t  e;
        resp_t r;
        prev_cmd   = 1'b0;
        active     = 1'b0;
        after_resp = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                check("rst_I_resp", I_resp, 0);
                check("rst_D_resp", D_resp, 0);
                check("rst_L2_read", L2_read, 0);
                check("rst_L2_write", L2_write, 0);
                check("rst_L2_addr", L2_addr, 0);
                check("rst_L2_wdata", L2_wdata, 0);
                prev_cmd   = 1'b0;
                active     = 1'b0;
                after_resp = 1'b0;
            end else begin
                if (after_resp)
                    check("cmd_clear_after_resp", L2_read | L2_write, 0);
                after_resp = 1'b0;
                if (I_resp || D_resp) begin
                    check("resp_exclusive", I_resp & D_resp, 0);
                    if (resp_q.size() == 0) begin
                        fail_now("unexpected_resp");
                    end else begin
                        r = resp_q.pop_front();
                        check("I_resp", I_resp, !r.who_d);
                        check("D_resp", D_resp, r.who_d);
                        if (r.who_d) check("D_rdata", D_rdata, r.data);
                        else         check("I_rdata", I_rdata, r.data);
                    end
                    after_resp = 1'b1;
                    active     = 1'b0;
                end
                cmd = L2_read | L2_write;
                if (cmd && !prev_cmd) begin
                    if (cmd_q.size() == 0) begin
                        fail_now("unexpected_cmd");
                    end else begin
                        e = cmd_q.pop_front();
                        check("cmd_latency", cyc, e.cyc);
                        check("L2_read", L2_read, e.rd);
                        check("L2_write", L2_write, e.wr);
                        check("L2_addr", L2_addr, e.addr);
                        if (e.who_d) check("L2_wdata", L2_wdata, e.wdata);
                        cur    = e;
                        active = 1'b1;
                    end
                end else if (cmd && active) begin
                    check("stable_L2_read", L2_read, cur.rd);
                    check("stable_L2_write", L2_write, cur.wr);
                    check("stable_L2_addr", L2_addr, cur.addr);
                    if (cur.who_d) check("stable_L2_wdata", L2_wdata, cur.wdata);
                end
                prev_cmd = cmd;
            end
        end
    end

    // ------------------------------------------------------------------ driver
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        if (n > 0) post_resp = 1'b0;
    endtask

    task automatic raise_i();
        I_read = 1'b1;
        I_addr = 16'($urandom());
    endtask

    task automatic raise_d();
        int op;
        op      = $urandom_range(0, 2);
        D_addr  = 16'($urandom());
        D_wdata = rand128();
        D_read  = (op != 1);
        D_write = (op != 0);
    endtask

    // Reference decision: lone requester wins; a tie goes to the one not served last.
    task automatic issue(input int delay, output bit who_d);
        cmd_t e;
        who_d   = !(I_read && (!(D_read || D_write) || served_d_last));
        e.who_d = who_d;
        e.cyc   = cyc + delay;
        if (who_d) begin
            e.addr  = D_addr;
            e.wdata = D_wdata;
            e.wr    = D_write;
            e.rd    = !D_write;
        end else begin
            e.addr  = I_addr;
            e.wdata = '0;
            e.rd    = 1'b1;
            e.wr    = 1'b0;
        end
        cmd_q.push_back(e);
    endtask

    task automatic run_txn(input int lat);
        bit    who_d;
        int    delay;
        resp_t r;
        delay = post_resp ? 2 : 1;
        issue(delay, who_d);
        repeat (delay) @(negedge clk);
        repeat (lat) begin
            if (who_d) begin
                D_addr  = 16'($urandom());
                D_wdata = rand128();
            end else begin
                I_addr = 16'($urandom());
            end
            @(negedge clk);
        end
        L2_rdata = rand128();
        L2_resp  = 1'b1;
        r.who_d  = who_d;
        r.data   = L2_rdata;
        resp_q.push_back(r);
        @(negedge clk);
        L2_resp  = 1'b0;
        L2_rdata = rand128();
        if (who_d) begin
            D_read  = 1'b0;
            D_write = 1'b0;
        end else begin
            I_read = 1'b0;
        end
        served_d_last = who_d;
        post_resp     = 1'b1;
    endtask

    task automatic drain();
        while (I_read || D_read || D_write) run_txn($urandom_range(0, 3));
    endtask

    initial begin
        bit who_d;
        rst_n = 1'b1; I_read = 1'b0; I_addr = '0;
        D_read = 1'b0; D_write = 1'b0; D_addr = '0; D_wdata = '0;
        L2_rdata = '0; L2_resp = 1'b0;
        served_d_last = 1'b1;
        post_resp     = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Tie right after reset: I first, then D.
        raise_i();
        raise_d();
        run_txn(1);
        run_txn(0);

        // Both requesting continuously: strict alternation.
        raise_i();
        raise_d();
        for (int n = 0; n < 4; n++) begin
            run_txn($urandom_range(0, 2));
            if (served_d_last) raise_d(); else raise_i();
        end
        drain();
        idle(2);

        // Single I read with 3-cycle L2 latency.
        I_read = 1'b1;
        I_addr = 16'h1230;
        run_txn(3);
        idle(2);

        // Single D write-back.
        D_write = 1'b1;
        D_read  = 1'b0;
        D_addr  = 16'h4000;
        D_wdata = {16{8'hA5}};
        run_txn(2);
        idle(2);

        // Stray L2_resp while idle must produce nothing.
        L2_rdata = rand128();
        L2_resp  = 1'b1;
        @(negedge clk);
        L2_resp = 1'b0;
        raise_i();
        run_txn(1);

        // Randomized mixed traffic.
        for (int n = 0; n < 40; n++) begin
            if (!I_read && $urandom_range(0, 1) == 1) raise_i();
            if (!(D_read || D_write) && $urandom_range(0, 1) == 1) raise_d();
            if (!I_read && !(D_read || D_write)) begin
                idle($urandom_range(0, 2));
                if ($urandom_range(0, 1) == 1) raise_i(); else raise_d();
            end
            run_txn($urandom_range(0, 4));
        end
        drain();
        idle(2);

        // Reset in the middle of a D write grant.
        D_write = 1'b1;
        D_read  = 1'b0;
        D_addr  = 16'($urandom());
        D_wdata = rand128();
        issue(1, who_d);
        @(negedge clk);
        #4;
        check("pre_rst_L2_write", L2_write, 1);
        rst_n   = 1'b0;
        L2_resp = 1'b1;
        #1;
        check("async_rst_L2_write", L2_write, 0);
        check("async_rst_D_resp", D_resp, 0);
        D_write = 1'b0;
        repeat (2) @(negedge clk);
        L2_resp       = 1'b0;
        rst_n         = 1'b1;
        served_d_last = 1'b1;
        post_resp     = 1'b0;
        idle(1);

        // First tie after reset goes to I.
        raise_i();
        raise_d();
        drain();
        idle(3);

        check("cmd_q_drained", cmd_q.size(), 0);
        check("resp_q_drained", resp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
